// File: rtl/dra_run_ctrl.sv
// DRA core run controller: sequences core reset, run enable and drain from the peripheral's reset/start levels.
// Define DRA_RUN_CTRL_TIMEOUT_EN to add the drain timeout counter and the ERR state; otherwise DRAIN waits forever.
module dra_run_ctrl #(
  parameter int unsigned RST_HOLD_CYCLES = 16,
  parameter int unsigned DRAIN_TIMEOUT   = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_reset_en,
  input  logic        i_start_en,
  input  logic        i_core_idle,
  output logic        o_dra_rst,
  output logic        o_dra_run,
  output logic [2:0]  o_state,
  output logic [15:0] o_run_cnt,
  output logic        o_err_timeout
);

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_READY = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  localparam logic [15:0] HOLD_INIT = 16'(RST_HOLD_CYCLES - 1);

  if (RST_HOLD_CYCLES < 1 || RST_HOLD_CYCLES > 65535 ||
      DRAIN_TIMEOUT < 1 || DRAIN_TIMEOUT > 65535) begin : g_param_check
    $error("dra_run_ctrl: RST_HOLD_CYCLES and DRAIN_TIMEOUT must be in 1..65535");
  end

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t      state_p0, state_p1;
  logic [15:0] hold_p0, hold_p1;
  logic [15:0] run_cnt_p0, run_cnt_p1;
  logic        dra_rst_p1, dra_run_p1;

`ifdef DRA_RUN_CTRL_TIMEOUT_EN
  localparam logic [15:0] DRAIN_TERM = 16'(DRAIN_TIMEOUT - 1);
  logic [15:0] drain_p0, drain_p1;
  logic        err_p0, err_p1;
`endif

  always_comb begin
    state_p0   = state_p1;
    hold_p0    = hold_p1;
    run_cnt_p0 = run_cnt_p1;
`ifdef DRA_RUN_CTRL_TIMEOUT_EN
    drain_p0   = drain_p1;
    err_p0     = err_p1;
`endif
    // A reset request overrides everything, including an in-progress hold countdown.
    if (i_reset_en) begin
      state_p0 = ST_RESET;
      hold_p0  = HOLD_INIT;
`ifdef DRA_RUN_CTRL_TIMEOUT_EN
      err_p0   = 1'b0;
`endif
    end else begin
      unique case (state_p1)
        ST_RESET: begin
          if (hold_p1 == 16'd0) state_p0 = ST_READY;
          else                  hold_p0  = hold_p1 - 16'd1;
        end
        ST_READY: begin
          if (i_start_en) begin
            state_p0   = ST_RUN;
            run_cnt_p0 = sat_inc16(run_cnt_p1);
          end
        end
        ST_RUN: begin
          if (!i_start_en) begin
            state_p0 = ST_DRAIN;
`ifdef DRA_RUN_CTRL_TIMEOUT_EN
            drain_p0 = 16'd0;
`endif
          end
        end
        ST_DRAIN: begin
          // Idle has priority over a timeout landing in the same cycle.
          if (i_core_idle) begin
            state_p0 = ST_READY;
          end
`ifdef DRA_RUN_CTRL_TIMEOUT_EN
          else if (drain_p1 == DRAIN_TERM) begin
            state_p0 = ST_ERR;
            err_p0   = 1'b1;
          end else begin
            drain_p0 = sat_inc16(drain_p1);
          end
`endif
        end
        ST_ERR: begin
          state_p0 = ST_ERR;
        end
        default: begin
          state_p0 = ST_RESET;
          hold_p0  = HOLD_INIT;
        end
      endcase
    end
  end

  // Stage boundary: state, counters and core-facing controls registered together.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_p1   <= ST_RESET;
      hold_p1    <= HOLD_INIT;
      run_cnt_p1 <= 16'd0;
      dra_rst_p1 <= 1'b1;
      dra_run_p1 <= 1'b0;
    end else begin
      state_p1   <= state_p0;
      hold_p1    <= hold_p0;
      run_cnt_p1 <= run_cnt_p0;
      dra_rst_p1 <= (state_p0 == ST_RESET);
      dra_run_p1 <= (state_p0 == ST_RUN);
    end
  end

`ifdef DRA_RUN_CTRL_TIMEOUT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      drain_p1 <= 16'd0;
      err_p1   <= 1'b0;
    end else begin
      drain_p1 <= drain_p0;
      err_p1   <= err_p0;
    end
  end

  assign o_err_timeout = err_p1;
`else
  assign o_err_timeout = 1'b0;
`endif

  assign o_dra_rst = dra_rst_p1;
  assign o_dra_run = dra_run_p1;
  assign o_state   = state_p1;
  assign o_run_cnt = run_cnt_p1;

endmodule

// File: tb/tb_dra_run_ctrl.sv
// Bench for dra_run_ctrl: directed phases then random levels, every cycle compared with a behavioural model.
module tb_dra_run_ctrl;
  localparam int HOLD = 16;
  localparam int DT   = 8;
`ifdef DRA_RUN_CTRL_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_reset_en = 1'b0;
  logic        i_start_en = 1'b0;
  logic        i_core_idle = 1'b0;
  logic        o_dra_rst, o_dra_run, o_err_timeout;
  logic [2:0]  o_state;
  logic [15:0] o_run_cnt;

  int    n_vec = 0;
  int    n_err = 0;
  string phase = "init";

  // Model: mode uses the published state numbers; hold_left = RESET cycles still owed;
  // age = completed DRAIN cycles without idle.
  int m_mode, m_hold_left, m_age, m_runs;
  bit m_err;

  always #5 i_clk = ~i_clk;

  dra_run_ctrl #(.RST_HOLD_CYCLES(HOLD), .DRAIN_TIMEOUT(DT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_reset_en(i_reset_en), .i_start_en(i_start_en),
    .i_core_idle(i_core_idle), .o_dra_rst(o_dra_rst), .o_dra_run(o_dra_run),
    .o_state(o_state), .o_run_cnt(o_run_cnt), .o_err_timeout(o_err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s [%s] observed=%0h expected=%0h", tag, phase, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_hold_left = HOLD; m_age = 0; m_runs = 0; m_err = 1'b0;
  endtask

  task automatic model_step(input bit re, input bit se, input bit idle);
    if (re) begin
      m_mode = 0; m_hold_left = HOLD; m_err = 1'b0;
    end else if (m_mode == 0) begin
      m_hold_left = m_hold_left - 1;
      if (m_hold_left == 0) m_mode = 1;
    end else if (m_mode == 1) begin
      if (se) begin
        m_mode = 2;
        if (m_runs < 65535) m_runs = m_runs + 1;
      end
    end else if (m_mode == 2) begin
      if (!se) begin m_mode = 3; m_age = 0; end
    end else if (m_mode == 3) begin
      if (idle) m_mode = 1;
      else begin
        m_age = m_age + 1;
        if (TIMEOUT_EN && m_age >= DT) begin m_mode = 4; m_err = 1'b1; end
      end
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk(tag, {10'd0, o_dra_rst, o_dra_run, o_state, o_run_cnt, o_err_timeout},
             {10'd0, (m_mode == 0), (m_mode == 2), 3'(m_mode), 16'(m_runs), m_err});
  endtask

  task automatic cyc(input bit rst, input bit re, input bit se, input bit idle);
    @(negedge i_clk);
    i_rst = rst; i_reset_en = re; i_start_en = se; i_core_idle = idle;
    @(posedge i_clk);
    if (rst) model_reset();
    else     model_step(re, se, idle);
    #1 chk_outputs("outputs");
  endtask

  task automatic hold_until_ready(output int n);
    n = 0;
    do begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end while (o_dra_rst && n < 200);
  endtask

  initial begin
    int n;
    model_reset();

    phase = "por";
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_state", 32'(o_state), 0);
    chk("rst_dra_rst", 32'(o_dra_rst), 1);
    chk("rst_dra_run", 32'(o_dra_run), 0);
    chk("rst_run_cnt", 32'(o_run_cnt), 0);
    chk("rst_err", 32'(o_err_timeout), 0);

    phase = "hold";
    hold_until_ready(n);
    chk("hold_cycles", 32'(n), HOLD);
    chk("hold_exit_ready", 32'(o_state), 1);

    phase = "start";
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("run_after_start", 32'(o_dra_run), 1);
    chk("run_cnt_first", 32'(o_run_cnt), 1);
    repeat (4) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("drain_state", 32'(o_state), 3);
    chk("drain_run_low", 32'(o_dra_run), 0);

    phase = "drain_idle";
    repeat (TIMEOUT_EN ? 5 : 9) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("drain_ignores_start", 32'(o_state), 3);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("idle_to_ready", 32'(o_state), 1);
    chk("idle_no_err", 32'(o_err_timeout), 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("ready_then_run", 32'(o_state), 2);
    chk("run_cnt_second", 32'(o_run_cnt), 2);

    phase = "timeout";
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    if (TIMEOUT_EN) begin
      repeat (DT - 1) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("pre_timeout_drain", 32'(o_state), 3);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("timeout_err_state", 32'(o_state), 4);
      chk("timeout_err_flag", 32'(o_err_timeout), 1);
      repeat (5) cyc(1'b0, 1'b0, 1'b1, 1'b1);
      chk("err_sticky", 32'(o_state), 4);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      chk("err_reset_state", 32'(o_state), 0);
      chk("err_flag_cleared", 32'(o_err_timeout), 0);
      hold_until_ready(n);
      chk("err_hold_cycles", 32'(n), HOLD);
    end else begin
      repeat (2000) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("no_timeout_drain", 32'(o_state), 3);
      chk("no_timeout_flag", 32'(o_err_timeout), 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("late_idle_ready", 32'(o_state), 1);
    end

    phase = "reset_en";
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("reset_en_run_low", 32'(o_dra_run), 0);
    chk("reset_en_rst_high", 32'(o_dra_rst), 1);
    repeat (19) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    hold_until_ready(n);
    chk("reset_en_tail", 32'(n), HOLD);
    chk("run_cnt_kept", 32'(o_run_cnt), 32'(m_runs));

    phase = "async_run";
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    #2 i_rst = 1'b1;
    #1 chk("async_run_state", {o_dra_rst, o_dra_run, o_state, o_run_cnt, o_err_timeout},
           {1'b1, 1'b0, 3'd0, 16'd0, 1'b0});
    model_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    hold_until_ready(n);
    chk("async_run_restart", 32'(n), HOLD);

    phase = "async_drain";
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    #2 i_rst = 1'b1;
    #1 chk("async_drain_state", {o_dra_rst, o_dra_run, o_state, o_run_cnt, o_err_timeout},
           {1'b1, 1'b0, 3'd0, 16'd0, 1'b0});
    model_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    hold_until_ready(n);
    chk("async_drain_restart", 32'(n), HOLD);

    phase = "random";
    begin
      bit se;
      se = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 99) < 15) se = ~se;
        cyc(1'b0, ($urandom_range(0, 99) < 2), se, ($urandom_range(0, 3) == 0));
      end
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    hold_until_ready(n);

    // Running 65535 real starts would take ~200k cycles, so the counter is preset near saturation.
    phase = "saturate";
    force dut.run_cnt_p1 = 16'hFFFE;
    #1 release dut.run_cnt_p1;
    m_runs = 16'hFFFE;
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("sat_reach", 32'(o_run_cnt), 32'hFFFF);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("sat_hold", 32'(o_run_cnt), 32'hFFFF);
    chk("sat_run", 32'(o_state), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dra_run_ctrl.md
DRA_RUN_CTRL -- requirements
Module: dra_run_ctrl

Interface
REQ-001 SHALL have parameter RST_HOLD_CYCLES, default 16: cycles o_dra_rst stays high after i_reset_en falls; legal range 1..65535.
REQ-002 SHALL have parameter DRAIN_TIMEOUT, default 1024: cycles DRAIN may last before error; legal range 1..65535.
REQ-003 SHALL have port i_clk, input, 1: single clock for all logic.
REQ-004 SHALL have port i_rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port i_reset_en, input, 1: DRA reset request level from the DRA configuration peripheral, i_clk domain.
REQ-006 SHALL have port i_start_en, input, 1: DRA start request level from the DRA configuration peripheral, i_clk domain.
REQ-007 SHALL have port i_core_idle, input, 1: DRA core reports no packet in flight.
REQ-008 SHALL have port o_dra_rst, output, 1: synchronous reset to the DRA core, registered.
REQ-009 SHALL have port o_dra_run, output, 1: run enable to the DRA core, registered.
REQ-010 SHALL have port o_state, output, 3: current state encoding, RESET=0, READY=1, RUN=2, DRAIN=3, ERR=4.
REQ-011 SHALL have port o_run_cnt, output, 16: number of READY->RUN transitions, saturating at 16'hFFFF.
REQ-012 SHALL have port o_err_timeout, output, 1: sticky drain-timeout flag.

Function
REQ-013 SHALL drive all outputs from registers; no combinational path from any input to any output.
REQ-014 SHALL give i_reset_en=1 priority over every other input in every state: next state RESET, hold counter loaded with RST_HOLD_CYCLES-1.
REQ-015 In RESET, with i_reset_en=0, SHALL decrement the hold counter once per cycle and go to READY in the cycle after the counter reads 0, so o_dra_rst stays high exactly RST_HOLD_CYCLES cycles after i_reset_en falls.
REQ-016 SHALL drive o_dra_rst=1 only in RESET and o_dra_run=1 only in RUN.
REQ-017 READY: i_start_en=1 SHALL go to RUN on the next edge (o_dra_run high 1 cycle after i_start_en is sampled), and increment o_run_cnt unless it already reads 16'hFFFF.
REQ-018 SHALL not skip READY: i_start_en already high on RESET exit gives one READY cycle, then RUN.
REQ-019 RUN: i_start_en=0 SHALL go to DRAIN and clear the drain counter.
REQ-020 DRAIN: i_core_idle=1 SHALL go to READY; i_start_en returning high in DRAIN is ignored until READY is reached.
REQ-021 DRAIN timeout (see REQ-027) SHALL go to ERR and set o_err_timeout; i_core_idle=1 in the same cycle as the timeout wins and the next state is READY.
REQ-022 ERR SHALL be left only by i_reset_en=1; o_err_timeout SHALL clear on entry to RESET.
REQ-023 Drain counter SHALL be 16 bits and SHALL not wrap; it stops at its terminal value.

Reset
REQ-024 On i_rst=1, state SHALL be RESET with hold counter = RST_HOLD_CYCLES-1, o_dra_rst=1, o_dra_run=0, o_state=0, o_run_cnt=0, o_err_timeout=0, drain counter=0.
REQ-025 i_rst asserted mid-RUN or mid-DRAIN SHALL force the REQ-024 values immediately (asynchronously), and the core reset sequence SHALL restart on release.
REQ-026 o_run_cnt SHALL be cleared only by i_rst, not by i_reset_en.

Configuration
REQ-027 With macro DRA_RUN_CTRL_TIMEOUT_EN defined: DRAIN times out when the drain counter reaches DRAIN_TIMEOUT-1 with i_core_idle=0, then REQ-021 applies.
REQ-028 Without DRA_RUN_CTRL_TIMEOUT_EN: no drain counter, DRAIN waits indefinitely for i_core_idle, ERR is unreachable, o_err_timeout is tied 0.

Verification
REQ-029 Release i_rst, i_reset_en=0, RST_HOLD_CYCLES=16 -> o_dra_rst high 16 cycles after release, o_state 0 then 1.
REQ-030 READY, i_start_en pulse high at cycle T -> o_dra_run=1 at T+1, o_run_cnt 0->1; i_start_en low at T+5 -> o_state=3 at T+6, o_dra_run=0.
REQ-031 DRAIN, i_core_idle=1 after 10 cycles -> o_state=1, o_err_timeout=0; with i_start_en still high -> RUN one cycle after READY.
REQ-032 Macro defined, DRAIN_TIMEOUT=8, i_core_idle held 0 -> o_state=4 and o_err_timeout=1 after 8 DRAIN cycles; i_reset_en pulse -> RESET, o_err_timeout=0; macro undefined -> stays DRAIN for 2000 cycles.
REQ-033 i_reset_en=1 during RUN -> o_dra_run=0 and o_dra_rst=1 next cycle; i_reset_en held 20 cycles -> o_dra_rst high 20+16 cycles.
REQ-034 Force o_run_cnt to 16'hFFFF via 65535 start cycles, then one more start -> o_run_cnt stays 16'hFFFF.
